// File: rtl/serial_dft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_dft_pkg
//  Brief    : Shared constants and helpers for the serial DFT correlator bank
//  Revision : 1.0  initial release
// ============================================================================
package serial_dft_pkg;

   // Input mode selection for COMPLEX_IN
   localparam int MODE_REAL    = 0;
   localparam int MODE_COMPLEX = 1;

   // Width of the sample index; at least one bit even for single-sample frames
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Largest positive value of a w-bit signed number (w must be <= 63)
   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Saturating add of two values already sign-extended to 64 bits;
   // result is clamped to the w-bit signed range
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int w);
      logic signed [63:0] s;
      s = a + b;
      if (s > sat_max(w))
         return sat_max(w);
      else if (s < (-sat_max(w) - 64'sd1))
         return -sat_max(w) - 64'sd1;
      else
         return s;
   endfunction

   // Flags whether sat_add with the same operands would clamp
   function automatic logic sat_ovf(input logic signed [63:0] a,
                                    input logic signed [63:0] b,
                                    input int w);
      logic signed [63:0] s;
      s = a + b;
      return (s > sat_max(w)) || (s < (-sat_max(w) - 64'sd1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_dft_bank_cmac.sv
`default_nettype none
// ============================================================================
//  Module   : dft_cmac
//  Brief    : One channel x bin complex multiply-accumulate with saturation
//             and a per-frame sticky overflow flag
//  Revision : 1.0  initial release
// ============================================================================
module dft_cmac
   import serial_dft_pkg::*;
#(
   parameter int W_WIDTH    = 16,
   parameter int X_WIDTH    = 16,
   parameter int S_WIDTH    = 40,
   parameter int COMPLEX_IN = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en_i,
   input  logic                      last_i,
   input  logic signed [X_WIDTH-1:0] x_re_i,
   input  logic signed [X_WIDTH-1:0] x_im_i,
   input  logic signed [W_WIDTH-1:0] w_re_i,
   input  logic signed [W_WIDTH-1:0] w_im_i,
   output logic signed [S_WIDTH-1:0] sum_re_o,
   output logic signed [S_WIDTH-1:0] sum_im_o,
   output logic                      sat_o
);

   // One extra bit holds the complex-mode sum of two full products
   localparam int P_WIDTH = W_WIDTH + X_WIDTH + 1;

   logic signed [P_WIDTH-1:0] xr, xi, wr, wi, pr, pi;
   logic signed [S_WIDTH-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic                      sticky_q, sticky_d;
   logic                      sat_now;

   assign xr = P_WIDTH'(x_re_i);
   assign xi = P_WIDTH'(x_im_i);
   assign wr = P_WIDTH'(w_re_i);
   assign wi = P_WIDTH'(w_im_i);

   generate
      if (COMPLEX_IN == MODE_COMPLEX) begin : g_complex
         assign pr = xr * wr - xi * wi;
         assign pi = xr * wi + xi * wr;
      end else begin : g_real
         logic unused_x_im;
         assign unused_x_im = ^xi;
         assign pr = xr * wr;
         assign pi = xr * wi;
      end
   endgenerate

   // Running sum including this cycle's product; the top latches it on frame end
   assign sum_re_o = S_WIDTH'(sat_add(64'(acc_re_q), 64'(pr), S_WIDTH));
   assign sum_im_o = S_WIDTH'(sat_add(64'(acc_im_q), 64'(pi), S_WIDTH));
   assign sat_now  = sat_ovf(64'(acc_re_q), 64'(pr), S_WIDTH) |
                     sat_ovf(64'(acc_im_q), 64'(pi), S_WIDTH);
   assign sat_o    = sticky_q | sat_now;

   // Accumulate on accept; clear accumulator and sticky flag at frame end
   always_comb begin
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      sticky_d = sticky_q;
      if (en_i) begin
         if (last_i) begin
            acc_re_d = '0;
            acc_im_d = '0;
            sticky_d = 1'b0;
         end else begin
            acc_re_d = sum_re_o;
            acc_im_d = sum_im_o;
            sticky_d = sat_o;
         end
      end
   end

   // Accumulator state register
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_re_q <= '0;
         acc_im_q <= '0;
         sticky_q <= 1'b0;
      end else begin
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         sticky_q <= sticky_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_dft_bank.sv
`default_nettype none
// ============================================================================
//  Module   : serial_dft_bank
//  Brief    : Serial DFT correlator bank: sample counter, valid/ready
//             handshakes and one-frame result buffer around a CMAC array
//  Revision : 1.0  initial release
// ============================================================================
module serial_dft_bank
   import serial_dft_pkg::*;
#(
   parameter int W_WIDTH      = 16,
   parameter int X_WIDTH      = 16,
   parameter int S_WIDTH      = 40,
   parameter int FRAME_LENGTH = 8,
   parameter int CHANELS      = 2,
   parameter int BINS         = 2,
   parameter int COMPLEX_IN   = 0
) (
   input  logic                                         clk,
   input  logic                                         rst,
   output logic [idx_width(FRAME_LENGTH)-1:0]           sample_idx,
   input  logic [BINS-1:0][W_WIDTH-1:0]                 w_re,
   input  logic [BINS-1:0][W_WIDTH-1:0]                 w_im,
   input  logic                                         valid_i,
   output logic                                         ready_o,
   input  logic [CHANELS-1:0][X_WIDTH-1:0]              x_re,
   input  logic [CHANELS-1:0][X_WIDTH-1:0]              x_im,
   output logic [CHANELS-1:0][BINS-1:0][S_WIDTH-1:0]    re,
   output logic [CHANELS-1:0][BINS-1:0][S_WIDTH-1:0]    im,
   output logic                                         sat_o,
   output logic                                         valid_o,
   input  logic                                         ready_i,
   output logic                                         frame_done
);

   localparam int IW = idx_width(FRAME_LENGTH);

   logic [IW-1:0]                            idx_q, idx_d;
   logic                                     valid_q, valid_d;
   logic                                     sat_q, sat_d;
   logic [CHANELS-1:0][BINS-1:0][S_WIDTH-1:0] re_q, re_d, im_q, im_d;
   logic [CHANELS-1:0][BINS-1:0][S_WIDTH-1:0] sum_re, sum_im;
   logic [CHANELS*BINS-1:0]                  sat_vec;
   logic                                     is_last, accept, frame_end;

   assign is_last = (idx_q == IW'(FRAME_LENGTH - 1));
   // Only the frame-ending sample can stall: it needs the result buffer free
   assign ready_o   = !(valid_q && !ready_i && is_last);
   assign accept    = valid_i && ready_o;
   assign frame_end = accept && is_last;

   assign sample_idx = idx_q;
   assign valid_o    = valid_q;
   assign sat_o      = sat_q;
   assign re         = re_q;
   assign im         = im_q;
   assign frame_done = frame_end;

   generate
      for (genvar c = 0; c < CHANELS; c++) begin : g_ch
         for (genvar b = 0; b < BINS; b++) begin : g_bin
            dft_cmac #(
               .W_WIDTH    (W_WIDTH),
               .X_WIDTH    (X_WIDTH),
               .S_WIDTH    (S_WIDTH),
               .COMPLEX_IN (COMPLEX_IN)
            ) u_cmac (
               .clk      (clk),
               .rst      (rst),
               .en_i     (accept),
               .last_i   (is_last),
               .x_re_i   (x_re[c]),
               .x_im_i   (x_im[c]),
               .w_re_i   (w_re[b]),
               .w_im_i   (w_im[b]),
               .sum_re_o (sum_re[c][b]),
               .sum_im_o (sum_im[c][b]),
               .sat_o    (sat_vec[c*BINS+b])
            );
         end
      end
   endgenerate

   // Sample counter, output handshake and result buffer next state
   always_comb begin
      idx_d   = idx_q;
      valid_d = valid_q;
      sat_d   = sat_q;
      re_d    = re_q;
      im_d    = im_q;
      if (accept)
         idx_d = is_last ? '0 : idx_q + IW'(1);
      if (frame_end) begin
         valid_d = 1'b1;
         re_d    = sum_re;
         im_d    = sum_im;
         sat_d   = |sat_vec;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Control and result buffer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         valid_q <= 1'b0;
         sat_q   <= 1'b0;
         re_q    <= '0;
         im_q    <= '0;
      end else begin
         idx_q   <= idx_d;
         valid_q <= valid_d;
         sat_q   <= sat_d;
         re_q    <= re_d;
         im_q    <= im_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_dft_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_dft_bank
//  Brief    : Directed self-checking bench for serial_dft_bank
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_dft_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Instance A: real mode, 2 channels x 2 bins, 4-sample frames
   logic                   a_rst, a_valid_i, a_ready_o, a_sat, a_valid_o, a_ready_i, a_done;
   logic [1:0]             a_idx;
   logic [1:0][15:0]       a_w_re, a_w_im, a_x_re, a_x_im;
   logic [1:0][1:0][39:0]  a_re, a_im;

   // Instance B: complex mode, 1 channel x 1 bin, 4-sample frames
   logic                   bc_rst, b_valid_i, b_ready_o, b_sat, b_valid_o, b_ready_i, b_done;
   logic [1:0]             b_idx;
   logic [0:0][15:0]       b_w_re, b_w_im, b_x_re, b_x_im;
   logic [0:0][0:0][39:0]  b_re, b_im;

   // Instance C: narrow widths for saturation, 8-sample frames
   logic                   c_valid_i, c_ready_o, c_sat, c_valid_o, c_ready_i, c_done;
   logic [2:0]             c_idx;
   logic [0:0][7:0]        c_w_re, c_w_im, c_x_re, c_x_im;
   logic [0:0][0:0][16:0]  c_re, c_im;

   serial_dft_bank #(.W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(40), .FRAME_LENGTH(4),
                     .CHANELS(2), .BINS(2), .COMPLEX_IN(0)) u_a (
      .clk(clk), .rst(a_rst), .sample_idx(a_idx), .w_re(a_w_re), .w_im(a_w_im),
      .valid_i(a_valid_i), .ready_o(a_ready_o), .x_re(a_x_re), .x_im(a_x_im),
      .re(a_re), .im(a_im), .sat_o(a_sat), .valid_o(a_valid_o), .ready_i(a_ready_i),
      .frame_done(a_done));

   serial_dft_bank #(.W_WIDTH(16), .X_WIDTH(16), .S_WIDTH(40), .FRAME_LENGTH(4),
                     .CHANELS(1), .BINS(1), .COMPLEX_IN(1)) u_b (
      .clk(clk), .rst(bc_rst), .sample_idx(b_idx), .w_re(b_w_re), .w_im(b_w_im),
      .valid_i(b_valid_i), .ready_o(b_ready_o), .x_re(b_x_re), .x_im(b_x_im),
      .re(b_re), .im(b_im), .sat_o(b_sat), .valid_o(b_valid_o), .ready_i(b_ready_i),
      .frame_done(b_done));

   serial_dft_bank #(.W_WIDTH(8), .X_WIDTH(8), .S_WIDTH(17), .FRAME_LENGTH(8),
                     .CHANELS(1), .BINS(1), .COMPLEX_IN(0)) u_c (
      .clk(clk), .rst(bc_rst), .sample_idx(c_idx), .w_re(c_w_re), .w_im(c_w_im),
      .valid_i(c_valid_i), .ready_o(c_ready_o), .x_re(c_x_re), .x_im(c_x_im),
      .re(c_re), .im(c_im), .sat_o(c_sat), .valid_o(c_valid_o), .ready_i(c_ready_i),
      .frame_done(c_done));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Contiguous 4-sample frame on instance A with constant per-channel samples
   task automatic a_feed(input int x0, input int x1);
      for (int k = 0; k < 4; k++) begin
         a_valid_i = 1'b1;
         a_x_re[0] = 16'(x0);
         a_x_re[1] = 16'(x1);
         tick();
      end
      a_valid_i = 1'b0;
   endtask

   // Contiguous 8-sample frame on instance C
   task automatic c_feed(input int xv);
      for (int k = 0; k < 8; k++) begin
         c_valid_i = 1'b1;
         c_x_re[0] = 8'(xv);
         tick();
      end
      c_valid_i = 1'b0;
   endtask

   task automatic test_reset;
      a_rst = 1'b1; bc_rst = 1'b1;
      tick(); tick();
      a_rst = 1'b0; bc_rst = 1'b0;
      #1;
      n_cmp++; if (a_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", a_idx); end
      n_cmp++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", a_valid_o); end
      n_cmp++; if (a_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b want 0", a_sat); end
      n_cmp++; if (a_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", a_ready_o); end
      n_cmp++; if (a_re[0][0] !== 40'd0 || a_im[1][1] !== 40'd0) begin n_fail++; $display("FAIL reset_result: got re=%0d im=%0d want 0", a_re[0][0], a_im[1][1]); end
      n_cmp++; if (b_valid_o !== 1'b0 || c_sat !== 1'b0) begin n_fail++; $display("FAIL reset_bc: got bvalid=%0b csat=%0b want 0", b_valid_o, c_sat); end
   endtask

   task automatic test_dc;
      int pulses;
      pulses = 0;
      a_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a_valid_i = 1'b1;
         a_x_re[0] = 16'd100;
         a_x_re[1] = 16'd100;
         #1;
         n_cmp++; if (a_idx !== 2'(k)) begin n_fail++; $display("FAIL dc_idx: got %0d want %0d", a_idx, k); end
         n_cmp++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL dc_early_valid: got %0b want 0 at sample %0d", a_valid_o, k); end
         if (a_done === 1'b1) pulses++;
         n_cmp++; if (a_done !== (k == 3)) begin n_fail++; $display("FAIL dc_done: got %0b want %0b at sample %0d", a_done, (k == 3), k); end
         tick();
      end
      a_valid_i = 1'b0;
      n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL dc_pulses: got %0d want 1", pulses); end
      n_cmp++; if (a_valid_o !== 1'b1) begin n_fail++; $display("FAIL dc_valid: got %0b want 1", a_valid_o); end
      n_cmp++; if (a_re[0][0] !== 40'd6553600 || a_re[1][0] !== 40'd6553600) begin n_fail++; $display("FAIL dc_re_bin0: got %0d/%0d want 6553600", a_re[0][0], a_re[1][0]); end
      n_cmp++; if (a_im[0][0] !== 40'd0 || a_re[0][1] !== 40'd0) begin n_fail++; $display("FAIL dc_zero: got im00=%0d re01=%0d want 0", a_im[0][0], a_re[0][1]); end
      n_cmp++; if (a_im[0][1] !== 40'd6553600 || a_im[1][1] !== 40'd6553600) begin n_fail++; $display("FAIL dc_im_bin1: got %0d/%0d want 6553600", a_im[0][1], a_im[1][1]); end
      n_cmp++; if (a_sat !== 1'b0) begin n_fail++; $display("FAIL dc_sat: got %0b want 0", a_sat); end
      a_ready_i = 1'b1;
      tick();
      n_cmp++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL dc_consume: got %0b want 0", a_valid_o); end
      a_ready_i = 1'b0;
   endtask

   task automatic test_backpressure;
      a_ready_i = 1'b0;
      a_feed(100, 100);
      for (int k = 0; k < 3; k++) begin
         a_valid_i = 1'b1;
         a_x_re[0] = 16'd50;
         a_x_re[1] = 16'd50;
         tick();
      end
      a_valid_i = 1'b1;
      #1;
      n_cmp++; if (a_ready_o !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got ready=%0b done=%0b want 0/0", a_ready_o, a_done); end
      tick(); tick();
      n_cmp++; if (a_idx !== 2'd3) begin n_fail++; $display("FAIL bp_idx_hold: got %0d want 3", a_idx); end
      n_cmp++; if (a_valid_o !== 1'b1 || a_re[0][0] !== 40'd6553600) begin n_fail++; $display("FAIL bp_result_hold: got valid=%0b re=%0d want 1/6553600", a_valid_o, a_re[0][0]); end
      a_ready_i = 1'b1;
      #1;
      n_cmp++; if (a_ready_o !== 1'b1 || a_done !== 1'b1) begin n_fail++; $display("FAIL bp_release: got ready=%0b done=%0b want 1/1", a_ready_o, a_done); end
      tick();
      a_valid_i = 1'b0;
      a_ready_i = 1'b0;
      n_cmp++; if (a_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_stays: got %0b want 1", a_valid_o); end
      n_cmp++; if (a_re[0][0] !== 40'd3276800 || a_im[1][1] !== 40'd3276800) begin n_fail++; $display("FAIL bp_reload: got re=%0d im=%0d want 3276800", a_re[0][0], a_im[1][1]); end
      a_ready_i = 1'b1;
      tick();
      a_ready_i = 1'b0;
   endtask

   task automatic test_bubbles;
      int k;
      int v;
      k = 0;
      a_ready_i = 1'b1;
      for (int cyc = 0; cyc < 200 && k < 4; cyc++) begin
         v = int'($urandom_range(0, 1));
         a_valid_i = (v != 0);
         if (v != 0) begin
            a_x_re[0] = 16'(10 * (k + 1));
            a_x_re[1] = 16'(-5 * (k + 1));
         end else begin
            a_x_re[0] = 16'd999;
            a_x_re[1] = 16'(-999);
         end
         #1;
         n_cmp++; if (a_idx !== 2'(k)) begin n_fail++; $display("FAIL bub_idx: got %0d want %0d", a_idx, k); end
         tick();
         if (v != 0) k++;
      end
      a_valid_i = 1'b0;
      n_cmp++; if (k != 4) begin n_fail++; $display("FAIL bub_timeout: got %0d accepts want 4", k); end
      n_cmp++; if (a_valid_o !== 1'b1) begin n_fail++; $display("FAIL bub_valid: got %0b want 1", a_valid_o); end
      n_cmp++; if (a_re[0][0] !== 40'd1638400 || a_im[0][1] !== 40'd1638400) begin n_fail++; $display("FAIL bub_ch0: got re=%0d im=%0d want 1638400", a_re[0][0], a_im[0][1]); end
      n_cmp++; if (a_re[1][0] !== 40'(-819200) || a_im[1][1] !== 40'(-819200)) begin n_fail++; $display("FAIL bub_ch1: got re=%0d im=%0d want -819200", $signed(a_re[1][0]), $signed(a_im[1][1])); end
      n_cmp++; if (a_im[0][0] !== 40'd0 || a_re[1][1] !== 40'd0) begin n_fail++; $display("FAIL bub_zero: got %0d/%0d want 0", a_im[0][0], a_re[1][1]); end
      tick();
      a_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid;
      a_ready_i = 1'b0;
      a_feed(100, 100);
      a_valid_i = 1'b1;
      a_x_re[0] = 16'd7;
      a_x_re[1] = 16'd7;
      tick(); tick();
      a_valid_i = 1'b0;
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      n_cmp++; if (a_idx !== 2'd0) begin n_fail++; $display("FAIL rmid_idx: got %0d want 0", a_idx); end
      n_cmp++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b want 0", a_valid_o); end
      n_cmp++; if (a_re[0][0] !== 40'd0 || a_im[1][1] !== 40'd0) begin n_fail++; $display("FAIL rmid_result: got re=%0d im=%0d want 0", a_re[0][0], a_im[1][1]); end
      a_feed(100, 100);
      n_cmp++; if (a_valid_o !== 1'b1 || a_re[1][0] !== 40'd6553600 || a_im[0][1] !== 40'd6553600) begin n_fail++; $display("FAIL rmid_frame: got valid=%0b re=%0d im=%0d want 1/6553600/6553600", a_valid_o, a_re[1][0], a_im[0][1]); end
      a_ready_i = 1'b1;
      tick();
      a_ready_i = 1'b0;
   endtask

   task automatic test_complex;
      b_ready_i = 1'b1;
      b_w_re[0] = 16'd1;
      b_w_im[0] = 16'd2;
      for (int k = 0; k < 4; k++) begin
         b_valid_i = 1'b1;
         b_x_re[0] = 16'd3;
         b_x_im[0] = 16'd4;
         tick();
      end
      b_valid_i = 1'b0;
      n_cmp++; if (b_valid_o !== 1'b1) begin n_fail++; $display("FAIL cplx_valid: got %0b want 1", b_valid_o); end
      n_cmp++; if (b_re[0][0] !== 40'(-20)) begin n_fail++; $display("FAIL cplx_re: got %0d want -20", $signed(b_re[0][0])); end
      n_cmp++; if (b_im[0][0] !== 40'd40) begin n_fail++; $display("FAIL cplx_im: got %0d want 40", $signed(b_im[0][0])); end
      n_cmp++; if (b_sat !== 1'b0) begin n_fail++; $display("FAIL cplx_sat: got %0b want 0", b_sat); end
   endtask

   task automatic test_saturation;
      c_ready_i = 1'b1;
      c_w_re[0] = 8'd127;
      c_w_im[0] = 8'd0;
      c_feed(127);
      n_cmp++; if (c_re[0][0] !== 17'd65535 || c_sat !== 1'b1) begin n_fail++; $display("FAIL sat_pos: got re=%0d sat=%0b want 65535/1", $signed(c_re[0][0]), c_sat); end
      n_cmp++; if (c_im[0][0] !== 17'd0) begin n_fail++; $display("FAIL sat_im: got %0d want 0", $signed(c_im[0][0])); end
      c_feed(1);
      n_cmp++; if (c_re[0][0] !== 17'd1016 || c_sat !== 1'b0) begin n_fail++; $display("FAIL sat_clean: got re=%0d sat=%0b want 1016/0", $signed(c_re[0][0]), c_sat); end
      c_feed(-128);
      n_cmp++; if (c_re[0][0] !== 17'(-65536) || c_sat !== 1'b1) begin n_fail++; $display("FAIL sat_neg: got re=%0d sat=%0b want -65536/1", $signed(c_re[0][0]), c_sat); end
   endtask

   initial begin
      a_rst = 1'b1; bc_rst = 1'b1;
      a_valid_i = 1'b0; a_ready_i = 1'b0; a_x_re = '0; a_x_im = '0;
      a_w_re[0] = 16'd16384; a_w_im[0] = 16'd0;
      a_w_re[1] = 16'd0;     a_w_im[1] = 16'd16384;
      b_valid_i = 1'b0; b_ready_i = 1'b0; b_x_re = '0; b_x_im = '0; b_w_re = '0; b_w_im = '0;
      c_valid_i = 1'b0; c_ready_i = 1'b0; c_x_re = '0; c_x_im = '0; c_w_re = '0; c_w_im = '0;
      test_reset();
      test_dc();
      test_backpressure();
      test_bubbles();
      test_reset_mid();
      test_complex();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_dft_bank.md
Name: serial_dft_bank

Overview:
- Next-generation serial DFT correlator for the AC_PH cascade.
- Accumulates CHANELS parallel sample streams against BINS frequency bins at once, over a frame of FRAME_LENGTH samples.
- Adds three things the previous generation lacked: a complex-input mode, saturating accumulation with an overflow flag, and a valid/ready output handshake with a one-frame result buffer and input backpressure.
- Twiddles come from an external ROM addressed by the sample index this block drives.

Parameters:
- W_WIDTH, 16, signed twiddle width per component.
- X_WIDTH, 16, signed sample width per component.
- S_WIDTH, 40, signed accumulator/output width; must be >= W_WIDTH+X_WIDTH+1.
- FRAME_LENGTH, 8, samples per frame; >= 1.
- CHANELS, 2, parallel input channels.
- BINS, 2, frequency bins computed per channel.
- COMPLEX_IN, 0, 0 = real input (x_im ignored), 1 = complex input.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sample_idx  out  $clog2(FRAME_LENGTH) (min 1)  index of the next sample to accept; twiddle ROM address.
- w_re  in  [BINS][W_WIDTH]  twiddle real parts for sample_idx, valid in the same cycle.
- w_im  in  [BINS][W_WIDTH]  twiddle imaginary parts.
- valid_i  in  1  input sample valid.
- ready_o  out  1  block can accept a sample.
- x_re  in  [CHANELS][X_WIDTH]  sample real parts.
- x_im  in  [CHANELS][X_WIDTH]  sample imaginary parts.
- re  out  [CHANELS][BINS][S_WIDTH]  buffered frame result, real.
- im  out  [CHANELS][BINS][S_WIDTH]  buffered frame result, imaginary.
- sat_o  out  1  set if any accumulation saturated in the buffered frame.
- valid_o  out  1  result buffer holds an unconsumed frame.
- ready_i  in  1  downstream accepts the result.
- frame_done  out  1  pulse: the last sample of a frame is accepted this cycle.

Behaviour:
- Accept = valid_i & ready_o. Nothing changes on cycles without accept, so valid_i gaps are transparent.
- Reset values: sample_idx=0, all accumulators 0, re/im=0, sat_o=0, valid_o=0. ready_o=1 after reset.
- Reset mid-frame discards the partial frame and any buffered result.
- Products per (channel c, bin b), as full-precision signed values:
  - Real mode: pr = x_re*w_re, pi = x_re*w_im.
  - Complex mode: pr = x_re*w_re - x_im*w_im, pi = x_re*w_im + x_im*w_re.
- Products are sign-extended to S_WIDTH. Each add saturates to ±(2^(S_WIDTH-1)-1) / -2^(S_WIDTH-1), and any saturation sets a per-frame sticky flag.
- Accept with sample_idx < FRAME_LENGTH-1: acc += product; sample_idx++.
- Accept with sample_idx == FRAME_LENGTH-1 (frame_done=1):
  - re/im load acc+product (complete sum, saturated); sat_o loads the sticky flag OR this cycle's saturation.
  - Accumulators and sticky flag clear; sample_idx wraps to 0; valid_o=1 next cycle.
  - Latency: result visible 1 cycle after the last sample is accepted.
- FRAME_LENGTH=1: every accept is a frame end.
- Output handshake:
  - While valid_o=1, re/im/sat_o are held stable.
  - valid_o & ready_i with no simultaneous frame end: valid_o clears next cycle.
- Backpressure: ready_o = !(valid_o & !ready_i & sample_idx==FRAME_LENGTH-1). Only the last sample of a frame stalls; samples are never dropped or overwritten.
- Simultaneous consume and frame end (valid_o & ready_i & frame_done): buffer reloads with the new frame and valid_o stays 1.
- ready_o is combinational from ready_i; ready_i must not depend combinationally on ready_o.

Decomposition:
- Package serial_dft_pkg: saturating-add function, sample-index width function, COMPLEX_IN mode constants.
- One sub-module, dft_cmac: one channel×bin complex multiply-accumulate with saturation and sticky flag, instantiated CHANELS×BINS times under a generate.
- The top holds sample counter, handshake and result buffer.

Test Plan:
- DC, real mode, FRAME_LENGTH=4, bin0 w=(16384,0), bin1 w=(0,16384), x_re=100 all samples -> re[c][0]=6553600, im[c][0]=0; re[c][1]=0, im[c][1]=6553600; valid_o 1 cycle after 4th accept; frame_done pulses once.
- Complex mode, FRAME_LENGTH=4, x=(3,4), w=(1,2) constant -> re=-20, im=40, sat_o=0.
- Saturation, W=X=8, S_WIDTH=17, FRAME_LENGTH=8, x_re=127, w_re=127 -> re=65535 (not 129032), sat_o=1. Next clean frame -> sat_o=0.
- Backpressure: ready_i=0 after frame 1 completes; feed frame 2 -> ready_o=0 at sample_idx=7 and frame 1 result held. Raise ready_i -> sample accepted that cycle, frame 2 result loaded, valid_o stays 1.
- Bubbles: valid_i toggled randomly across a frame -> result equals the gap-free result; sample_idx advances only on accept.
- Reset after 2 accepted samples with a frame buffered -> next cycle sample_idx=0, valid_o=0, re/im=0; following frame matches the DC expectation.
